// File: rtl/tanh_fixed_to_fp32.sv
// tanh output stage: fixed-point magnitude + sign -> IEEE-754 fp32 (RNE, clamp at 1.0).
// Latency 3 cycles, one result per clock; no backpressure, stages load only on their valid bit.
module tanh_fixed_to_fp32 #(
  parameter int FRAC_BITS = 30
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        in_sign,
  input  logic [31:0] in_mag,
  output logic        out_valid,
  output logic [31:0] out_fp,
  output logic        out_sat
);

  localparam logic [31:0] ONE_FIX  = 32'd1 << FRAC_BITS;
  localparam logic [7:0]  EXP_BASE = 8'(158 - FRAC_BITS);

  logic        s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
  logic        s1_sat_q, s1_sat_d, s1_zero_q, s1_zero_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic [5:0]  s1_lzc_q, s1_lzc_d, lzc;

  logic        s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d;
  logic        s2_sat_q, s2_sat_d, s2_zero_q, s2_zero_d;
  logic [30:0] s2_norm_q, s2_norm_d;
  logic [7:0]  s2_exp_q, s2_exp_d;

  logic        out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [31:0] out_fp_q, out_fp_d;

  logic        round_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_rnd;

  // Highest set bit wins; an all-zero magnitude reports 32.
  always_comb begin
    lzc = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (in_mag[i]) lzc = 6'(31 - i);
    end
  end

  always_comb begin
    s1_vld_d  = in_valid;
    s1_sign_d = s1_sign_q;
    s1_mag_d  = s1_mag_q;
    s1_sat_d  = s1_sat_q;
    s1_zero_d = s1_zero_q;
    s1_lzc_d  = s1_lzc_q;
    if (in_valid) begin
      s1_sign_d = in_sign;
      s1_mag_d  = in_mag;
      s1_sat_d  = (in_mag >= ONE_FIX);
      s1_zero_d = (in_mag == 32'd0);
      s1_lzc_d  = lzc;
    end
  end

  // Bit 31 of the normalised value is the implicit one and is not stored.
  // Exponent fits 8 bits for every legal FRAC_BITS (96..127 after rounding).
  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_sign_d = s2_sign_q;
    s2_sat_d  = s2_sat_q;
    s2_zero_d = s2_zero_q;
    s2_norm_d = s2_norm_q;
    s2_exp_d  = s2_exp_q;
    if (s1_vld_q) begin
      s2_sign_d = s1_sign_q;
      s2_sat_d  = s1_sat_q;
      s2_zero_d = s1_zero_q;
      s2_norm_d = 31'(s1_mag_q << s1_lzc_q);
      s2_exp_d  = EXP_BASE - {2'b00, s1_lzc_q};
    end
  end

  // Carry out of the mantissa leaves the low 23 bits zero and bumps the exponent.
  always_comb begin
    round_up    = s2_norm_q[7] & ((|s2_norm_q[6:0]) | s2_norm_q[8]);
    mant_rnd    = {1'b0, s2_norm_q[30:8]} + {23'd0, round_up};
    exp_rnd     = s2_exp_q + {7'd0, mant_rnd[23]};
    out_valid_d = s2_vld_q;
    out_fp_d    = out_fp_q;
    out_sat_d   = out_sat_q;
    if (s2_vld_q) begin
      out_sat_d = s2_sat_q;
      if (s2_sat_q) begin
        out_fp_d = {s2_sign_q, 31'h3F80_0000};
      end else if (s2_zero_q) begin
        out_fp_d = {s2_sign_q, 31'h0};
      end else begin
        out_fp_d = {s2_sign_q, exp_rnd, mant_rnd[22:0]};
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_vld_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= 32'd0;
      s1_sat_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_lzc_q    <= 6'd0;
      s2_vld_q    <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_norm_q   <= 31'd0;
      s2_exp_q    <= 8'd0;
      out_valid_q <= 1'b0;
      out_fp_q    <= 32'd0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_sat_q    <= s1_sat_d;
      s1_zero_q   <= s1_zero_d;
      s1_lzc_q    <= s1_lzc_d;
      s2_vld_q    <= s2_vld_d;
      s2_sign_q   <= s2_sign_d;
      s2_sat_q    <= s2_sat_d;
      s2_zero_q   <= s2_zero_d;
      s2_norm_q   <= s2_norm_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      out_fp_q    <= out_fp_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_tanh_fixed_to_fp32.sv
// Bench for tanh_fixed_to_fp32: directed vector table, reset/latency sequences, random stream vs real-valued model.
module tb_tanh_fixed_to_fp32;

  localparam int FRAC_BITS = 30;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_sign;
  logic [31:0] in_mag;
  logic        out_valid;
  logic [31:0] out_fp;
  logic        out_sat;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        s;
    logic [31:0] m;
    logic [31:0] fp;
    logic        sat;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] fp;
    logic        sat;
  } exp_t;

  exp_t        pipe[$];
  logic [31:0] held_fp;
  logic        held_sat;
  vec_t        tbl[11];

  tanh_fixed_to_fp32 #(.FRAC_BITS(FRAC_BITS)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_sign  (in_sign),
    .in_mag   (in_mag),
    .out_valid(out_valid),
    .out_fp   (out_fp),
    .out_sat  (out_sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value = mag / 2^FRAC_BITS as a double (exact), then rounded to fp32 nearest-even.
  function automatic logic [32:0] ref_model(input logic s, input logic [31:0] m);
    real         v;
    logic [63:0] b;
    int          e;
    logic        g, st;
    logic [23:0] mr;
    v = real'(m) / (2.0 ** FRAC_BITS);
    if (v >= 1.0) return {1'b1, s, 31'h3F80_0000};
    if (v == 0.0) return {1'b0, s, 31'h0};
    b  = $realtobits(v);
    e  = int'(b[62:52]) - 1023 + 127;
    g  = b[28];
    st = |b[27:0];
    mr = {1'b0, b[51:29]};
    if (g && (st || mr[0])) mr = mr + 24'd1;
    if (mr[23]) e = e + 1;
    return {1'b0, s, 8'(e), mr[22:0]};
  endfunction

  task automatic pipe_clear();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back('{1'b0, 32'd0, 1'b0});
    held_fp  = 32'd0;
    held_sat = 1'b0;
  endtask

  // Called at a falling edge: checks what is due now, drives the next input, advances one cycle.
  task automatic cycle(input logic v, input logic s, input logic [31:0] m,
                       input logic [31:0] efp, input logic esat);
    exp_t e;
    e = pipe.pop_front();
    check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
    if (e.v) begin
      held_fp  = e.fp;
      held_sat = e.sat;
    end
    check("out_fp", out_fp, held_fp);
    check("out_sat", {31'd0, out_sat}, {31'd0, held_sat});
    pipe.push_back('{v, efp, esat});
    in_valid = v;
    in_sign  = s;
    in_mag   = m;
    @(negedge clock);
  endtask

  task automatic cycle_model(input logic v, input logic s, input logic [31:0] m);
    logic [32:0] r;
    r = ref_model(s, m);
    cycle(v, s, m, r[31:0], r[32]);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h2000_0000, 32'h3F00_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h2000_0000, 32'hBF00_0000, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0001, 32'h3080_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h2000_0020, 32'h3F00_0000, 1'b0};
    tbl[5]  = '{1'b0, 32'h2000_0060, 32'h3F00_0002, 1'b0};
    tbl[6]  = '{1'b0, 32'h3FFF_FFFF, 32'h3F80_0000, 1'b0};
    tbl[7]  = '{1'b0, 32'h4000_0000, 32'h3F80_0000, 1'b1};
    tbl[8]  = '{1'b1, 32'h7FFF_FFFF, 32'hBF80_0000, 1'b1};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'h3F80_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_mag   = 32'd0;
    repeat (2) @(negedge clock);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_fp", out_fp, 32'd0);
    check("reset out_sat", {31'd0, out_sat}, 32'd0);
    resetn = 1'b1;
    pipe_clear();

    // Fill the pipe, then pull reset between clock edges.
    for (int i = 0; i < 6; i++) cycle_model(1'b1, 1'b1, 32'h2000_0000 + 32'(i));
    #2 resetn = 1'b0;
    #1;
    check("async reset out_valid", {31'd0, out_valid}, 32'd0);
    check("async reset out_fp", out_fp, 32'd0);
    check("async reset out_sat", {31'd0, out_sat}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn   = 1'b1;
    in_valid = 1'b0;
    pipe_clear();

    // First sample after release must appear exactly three edges later.
    cycle(1'b1, 1'b0, 32'h2000_0000, 32'h3F00_0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h1234_5678, 32'd0, 1'b0);

    for (int i = 0; i < 11; i++) cycle(1'b1, tbl[i].s, tbl[i].m, tbl[i].fp, tbl[i].sat);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // Random stream with bubbles carrying junk data.
    for (int i = 0; i < 256; i++) begin
      logic        v;
      logic [31:0] m;
      int          kind;
      v    = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 3);
      m    = $urandom;
      if (kind == 1) m = m >> 2;
      else if (kind == 2) m = m >> $urandom_range(2, 31);
      else if (kind == 3) m = (m >> 2) & 32'h3FFF_FF00 | {24'd0, 8'($urandom_range(0, 3) << 6)};
      cycle_model(v, 1'($urandom_range(0, 1)), m);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
